// File: rtl/gpio_port.sv
// ---------------------------------------------------------------------------
// gpio_port -- memory-mapped general purpose I/O port.
//
// Register window (offset = ALU_out[3:0], base = BASE_ADDR[31:4]):
//   0 OUT  RW  pin output values
//   1 DIR  RW  per-pin output enable, 1 = drive
//   2 IN   RO  synchronised pin inputs
//   3 IE   RW  per-pin rising-edge interrupt enable
//   4 IS   W1C interrupt status, set by enabled rising edges
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   MemW, MemR            bus write / read strobes
//   ALU_out[31:0]         bus byte address
//   WD[31:0]              bus write data (bits above WIDTH ignored)
//   RD[31:0], RD_valid    registered read data and its one-cycle valid pulse
//   sel                   combinational address hit for offsets 0..4
//   gpio_in[WIDTH-1:0]    asynchronous pin inputs
//   gpio_out, gpio_oe     pin values and output enables, straight from flops
//   irq                   registered interrupt request
// ---------------------------------------------------------------------------
module gpio_port #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_ABC0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemW,
    input  logic             MemR,
    input  logic [31:0]      ALU_out,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    output logic             RD_valid,
    output logic             sel,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [3:0] OFF_OUT = 4'd0;
    localparam logic [3:0] OFF_DIR = 4'd1;
    localparam logic [3:0] OFF_IN  = 4'd2;
    localparam logic [3:0] OFF_IE  = 4'd3;
    localparam logic [3:0] OFF_IS  = 4'd4;

    // Zero-extend a pin-wide value onto the 32-bit read bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r            = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q,  ie_d;
    logic [WIDTH-1:0] is_q,  is_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [31:0]      rd_q,  rd_d;
    logic             rd_valid_q;
    logic             irq_q, irq_d;

    logic [3:0]       offset_s;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] is_clr_s;
    logic             unused_wd_s;

    // Only WD[WIDTH-1:0] carries register data; fold the rest into a sink.
    assign unused_wd_s = ^WD;

    assign offset_s = ALU_out[3:0];
    assign sel      = (ALU_out[31:4] == BASE_ADDR[31:4]) && (offset_s <= OFF_IS);

    // IN is simply the last synchroniser stage; rise compares it with one more flop.
    assign in_s   = sync_q[SYNC_STAGES-1];
    assign rise_s = in_s & ~prev_q;

    // Bus write decode and interrupt status next-state.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ie_d     = ie_q;
        is_clr_s = {WIDTH{1'b0}};
        if (MemW && sel) begin
            case (offset_s)
                OFF_OUT: out_d    = WD[WIDTH-1:0];
                OFF_DIR: dir_d    = WD[WIDTH-1:0];
                OFF_IN:  out_d    = out_q;          // read-only, write dropped
                OFF_IE:  ie_d     = WD[WIDTH-1:0];
                OFF_IS:  is_clr_s = WD[WIDTH-1:0];
                default: out_d    = out_q;
            endcase
        end else begin
            is_clr_s = {WIDTH{1'b0}};
        end
        // Set term is ORed after the clear so a same-cycle edge wins.
        // Bits with IE=0 are never cleared here by disabling; they just stop setting.
        is_d  = (is_q & ~is_clr_s) | (rise_s & ie_q);
        irq_d = |(is_q & ie_q);
    end

    // Read mux: register value is sampled before any same-cycle write lands.
    always_comb begin
        rd_d = 32'd0;
        if (MemR && sel) begin
            case (offset_s)
                OFF_OUT: rd_d = zext(out_q);
                OFF_DIR: rd_d = zext(dir_q);
                OFF_IN:  rd_d = zext(in_s);
                OFF_IE:  rd_d = zext(ie_q);
                OFF_IS:  rd_d = zext(is_q);
                default: rd_d = 32'd0;
            endcase
        end else begin
            rd_d = 32'd0;
        end
    end

    // Control/status registers, read port and interrupt flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= {WIDTH{1'b0}};
            dir_q      <= {WIDTH{1'b0}};
            ie_q       <= {WIDTH{1'b0}};
            is_q       <= {WIDTH{1'b0}};
            prev_q     <= {WIDTH{1'b0}};
            rd_q       <= 32'd0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            ie_q       <= ie_d;
            is_q       <= is_d;
            prev_q     <= in_s;
            rd_q       <= rd_d;
            rd_valid_q <= MemR;
            irq_q      <= irq_d;
        end
    end

    // Input synchroniser chain; restarts from zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign RD       = rd_q;
    assign RD_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// ---------------------------------------------------------------------------
// tb_gpio_port -- scoreboard bench for gpio_port.
// Instance 0: WIDTH=8, SYNC_STAGES=2, default base 0xABC0.
// Instance 1: WIDTH=32, SYNC_STAGES=3, base 0x80000010.
// Reads push their expected RD into a per-instance queue; a monitor on the
// falling edge pops and compares whenever RD_valid is seen.
// ---------------------------------------------------------------------------
module tb_gpio_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        memw [2];
    logic        memr [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];

    logic [31:0] rd_a,   rd_b;
    logic        rdv_a,  rdv_b;
    logic        sel_a,  sel_b;
    logic [7:0]  gin_a,  gout_a, goe_a;
    logic [31:0] gin_b,  gout_b, goe_b;
    logic        irq_a,  irq_b;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int checks = 0;
    int errors = 0;

    gpio_port #(.WIDTH(8), .BASE_ADDR(32'h0000_ABC0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .MemW(memw[0]), .MemR(memr[0]),
        .ALU_out(addr[0]), .WD(wd[0]), .RD(rd_a), .RD_valid(rdv_a), .sel(sel_a),
        .gpio_in(gin_a), .gpio_out(gout_a), .gpio_oe(goe_a), .irq(irq_a)
    );

    gpio_port #(.WIDTH(32), .BASE_ADDR(32'h8000_0010), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .MemW(memw[1]), .MemR(memr[1]),
        .ALU_out(addr[1]), .WD(wd[1]), .RD(rd_b), .RD_valid(rdv_b), .sel(sel_b),
        .gpio_in(gin_b), .gpio_out(gout_b), .gpio_oe(goe_b), .irq(irq_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d);
        memw[p] = 1'b1;
        addr[p] = a;
        wd[p]   = d;
        @(posedge clk);
        #1;
        memw[p] = 1'b0;
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        memr[p] = 1'b1;
        addr[p] = a;
        @(posedge clk);
        #1;
        memr[p] = 1'b0;
    endtask

    task automatic rw(input int p, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        memr[p] = 1'b1;
        memw[p] = 1'b1;
        addr[p] = a;
        wd[p]   = d;
        @(posedge clk);
        #1;
        memr[p] = 1'b0;
        memw[p] = 1'b0;
    endtask

    // Scoreboard monitor for instance 0.
    initial begin
        forever begin
            @(negedge clk);
            if (rdv_a === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL rd_a_unexpected: got RD_valid with RD=%h expected no read", rd_a);
                end else begin
                    if (rd_a !== q0[0]) begin
                        errors++;
                        $display("FAIL rd_a: got %h expected %h", rd_a, q0[0]);
                    end
                    void'(q0.pop_front());
                end
            end
        end
    end

    // Scoreboard monitor for instance 1.
    initial begin
        forever begin
            @(negedge clk);
            if (rdv_b === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL rd_b_unexpected: got RD_valid with RD=%h expected no read", rd_b);
                end else begin
                    if (rd_b !== q1[0]) begin
                        errors++;
                        $display("FAIL rd_b: got %h expected %h", rd_b, q1[0]);
                    end
                    void'(q1.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            memw[p] = 1'b0;
            memr[p] = 1'b0;
            addr[p] = 32'd0;
            wd[p]   = 32'd0;
        end
        gin_a = 8'h00;
        gin_b = 32'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_gpio_out", {24'd0, gout_a}, 32'h0);
        chk("reset_gpio_oe",  {24'd0, goe_a},  32'h0);
        chk("reset_irq",      {31'd0, irq_a},  32'h0);
        chk("reset_rd",       rd_a,            32'h0);
        chk("reset_rd_valid", {31'd0, rdv_a},  32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic write/read of OUT.
        wr(0, 32'h0000_ABC0, 32'h0000_00A5);
        chk("out_write", {24'd0, gout_a}, 32'hA5);
        rd(0, 32'h0000_ABC0, 32'h0000_00A5);

        // Address decode.
        addr[0] = 32'h0000_ABC0; #1 chk("sel_off0",   {31'd0, sel_a}, 32'd1);
        addr[0] = 32'h0000_ABC4; #1 chk("sel_off4",   {31'd0, sel_a}, 32'd1);
        addr[0] = 32'h0000_ABC5; #1 chk("sel_off5",   {31'd0, sel_a}, 32'd0);
        addr[0] = 32'h0000_ABCD; #1 chk("sel_offD",   {31'd0, sel_a}, 32'd0);
        addr[0] = 32'h0001_ABC0; #1 chk("sel_hibase", {31'd0, sel_a}, 32'd0);
        @(posedge clk);
        #1;

        // Writes outside the map change nothing; reads there return 0.
        wr(0, 32'h0000_ABCD, 32'hFF);
        wr(0, 32'h0000_ABC5, 32'hFF);
        wr(0, 32'h0000_ABD1, 32'hFF);
        chk("nosel_out", {24'd0, gout_a}, 32'hA5);
        chk("nosel_dir", {24'd0, goe_a},  32'h00);
        rd(0, 32'h0000_ABCD, 32'h0);
        rd(0, 32'h0000_ABC0, 32'hA5);
        rd(0, 32'h0000_ABC1, 32'h0);

        // DIR and read-only IN.
        wr(0, 32'h0000_ABC1, 32'h3C);
        chk("dir_write", {24'd0, goe_a}, 32'h3C);
        rd(0, 32'h0000_ABC1, 32'h3C);
        wr(0, 32'h0000_ABC2, 32'hFF);
        rd(0, 32'h0000_ABC2, 32'h00);
        gin_a = 8'h80;
        cyc(3);
        rd(0, 32'h0000_ABC2, 32'h80);
        rd(0, 32'h0000_ABC4, 32'h00);
        chk("irq_ie_off", {31'd0, irq_a}, 32'd0);

        // Enabled rising edge on pin 0: IS at 3 cycles, irq at 4.
        wr(0, 32'h0000_ABC3, 32'h01);
        gin_a = 8'h81;
        cyc(2);
        rd(0, 32'h0000_ABC4, 32'h00);
        chk("irq_before", {31'd0, irq_a}, 32'd0);
        rd(0, 32'h0000_ABC4, 32'h01);
        chk("irq_rise", {31'd0, irq_a}, 32'd1);
        rd(0, 32'h0000_ABC4, 32'h01);

        // Clear and new rise in the same cycle: set wins.
        gin_a = 8'h80;
        cyc(4);
        gin_a = 8'h81;
        cyc(2);
        wr(0, 32'h0000_ABC4, 32'h01);
        chk("setwins_irq0", {31'd0, irq_a}, 32'd1);
        cyc(1);
        chk("setwins_irq1", {31'd0, irq_a}, 32'd1);
        rd(0, 32'h0000_ABC4, 32'h01);

        // Plain W1C drops irq one cycle after the clear lands.
        wr(0, 32'h0000_ABC4, 32'h01);
        chk("w1c_irq_hold", {31'd0, irq_a}, 32'd1);
        cyc(1);
        chk("w1c_irq_low", {31'd0, irq_a}, 32'd0);
        rd(0, 32'h0000_ABC4, 32'h00);

        // Simultaneous read and write returns the old value.
        rw(0, 32'h0000_ABC0, 32'h5A, 32'hA5);
        chk("rw_new_out", {24'd0, gout_a}, 32'h5A);

        // Disabling IE keeps IS but drops irq.
        gin_a = 8'h80;
        cyc(4);
        gin_a = 8'h81;
        cyc(4);
        chk("irq_again", {31'd0, irq_a}, 32'd1);
        wr(0, 32'h0000_ABC3, 32'h00);
        cyc(1);
        chk("irq_ie_cleared", {31'd0, irq_a}, 32'd0);
        rd(0, 32'h0000_ABC4, 32'h01);
        wr(0, 32'h0000_ABC4, 32'hFF);
        rd(0, 32'h0000_ABC4, 32'h00);

        // Async reset mid-access.
        wr(0, 32'h0000_ABC1, 32'hF0);
        wr(0, 32'h0000_ABC0, 32'h3C);
        wr(0, 32'h0000_ABC3, 32'h01);
        gin_a = 8'h80;
        cyc(4);
        gin_a = 8'h81;
        cyc(4);
        chk("pre_rst_out", {24'd0, gout_a}, 32'h3C);
        chk("pre_rst_oe",  {24'd0, goe_a},  32'hF0);
        chk("pre_rst_irq", {31'd0, irq_a},  32'd1);
        memr[0] = 1'b1;
        addr[0] = 32'h0000_ABC0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        memr[0] = 1'b0;
        #1;
        chk("rst_out", {24'd0, gout_a}, 32'h0);
        chk("rst_oe",  {24'd0, goe_a},  32'h0);
        chk("rst_irq", {31'd0, irq_a},  32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Pin held high through reset gives one rise after SYNC_STAGES+1 edges.
        wr(0, 32'h0000_ABC3, 32'h01);
        cyc(1);
        chk("post_rst_irq0", {31'd0, irq_a}, 32'd0);
        rd(0, 32'h0000_ABC4, 32'h00);
        chk("post_rst_irq1", {31'd0, irq_a}, 32'd0);
        rd(0, 32'h0000_ABC4, 32'h01);
        chk("post_rst_irq2", {31'd0, irq_a}, 32'd1);
        chk("post_rst_out",  {24'd0, gout_a}, 32'h0);

        // Wide instance, three-stage synchroniser.
        wr(1, 32'h8000_0010, 32'hDEAD_BEEF);
        chk("b_out", gout_b, 32'hDEAD_BEEF);
        rd(1, 32'h8000_0010, 32'hDEAD_BEEF);
        wr(1, 32'h8000_0013, 32'h8000_0000);
        gin_b = 32'h8000_0000;
        cyc(3);
        rd(1, 32'h8000_0014, 32'h0);
        chk("b_irq0", {31'd0, irq_b}, 32'd0);
        rd(1, 32'h8000_0014, 32'h8000_0000);
        chk("b_irq1", {31'd0, irq_b}, 32'd1);
        rd(1, 32'h8000_0012, 32'h8000_0000);

        cyc(3);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins (1..32).
REQ-002 Parameter BASE_ADDR, default 32'h0000ABC0, byte address of register 0; low 4 bits SHALL be zero.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 MemW  input  1  bus write strobe.
REQ-007 MemR  input  1  bus read strobe.
REQ-008 ALU_out  input  32  bus byte address.
REQ-009 WD  input  32  bus write data; bits above WIDTH ignored.
REQ-010 RD  output  32  registered read data, zero-extended above WIDTH.
REQ-011 RD_valid  output  1  one-cycle pulse marking RD valid.
REQ-012 sel  output  1  combinational address hit: ALU_out[31:4]==BASE_ADDR[31:4] and ALU_out[3:0]<=4.
REQ-013 gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-014 gpio_out  output  WIDTH  pin output values.
REQ-015 gpio_oe  output  WIDTH  per-pin output enable, 1 = drive.
REQ-016 irq  output  WIDTH>0 ? 1 : 1  interrupt request, registered.

Function
REQ-017 Register map (offset = ALU_out[3:0]): 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 IE (RW, per-pin rising-edge interrupt enable), 4 IS (status, write-1-to-clear).
REQ-018 Write: when MemW=1 and sel=1, target register SHALL update at the next rising edge with WD[WIDTH-1:0]; writes to IN ignored.
REQ-019 Write with sel=0, or offsets 5..15 in the base window, SHALL change no state.
REQ-020 gpio_out SHALL equal OUT register and gpio_oe SHALL equal DIR register, both directly from flops, zero combinational path from bus.
REQ-021 gpio_in SHALL pass through a SYNC_STAGES-deep flop chain per bit; IN register = last synchroniser stage.
REQ-022 Edge detector: one further flop holds previous IN; rise[i] = IN[i] & ~prev[i].
REQ-023 IS[i] SHALL set when rise[i]=1 and IE[i]=1, regardless of DIR[i].
REQ-024 IS write: bits with WD[i]=1 clear; if clear and set occur for the same bit in the same cycle, set wins.
REQ-025 IS bits with IE[i]=0 SHALL hold their value (disabling does not clear).
REQ-026 irq SHALL be registered OR-reduction of (IS & IE), asserting one cycle after IS updates.
REQ-027 Read: MemR=1 and sel=1 captures selected register into RD at next edge and pulses RD_valid for exactly one cycle (latency 1); MemR with sel=0 pulses RD_valid with RD=0.
REQ-028 Simultaneous MemR and MemW to the same offset: RD SHALL return the pre-write value.
REQ-029 Read of IS SHALL not clear it.
REQ-030 Latency pin-to-IN: SYNC_STAGES cycles; pin-to-IS: SYNC_STAGES+1 cycles; pin-to-irq: SYNC_STAGES+2 cycles.

Reset
REQ-031 On rst_n=0, immediately and independent of clk: OUT, DIR, IE, IS, synchroniser, prev, RD, RD_valid, irq SHALL all be 0; gpio_oe=0 (all pins input).
REQ-032 Reset asserted mid-access SHALL abort it; no RD_valid after rst_n release until a new MemR.
REQ-033 First rising edge after rst_n deassertion SHALL be fully functional; synchroniser reloads from 0, so a pin held high at release produces one rise event SYNC_STAGES+1 cycles later.

Verification
REQ-034 WIDTH=8: MemW=1, ALU_out=0xABC0, WD=0xA5 -> gpio_out=0xA5 next edge; MemR same address -> RD=0x000000A5, RD_valid one cycle.
REQ-035 MemW=1, ALU_out=0xABCD (outside map), WD=0xFF -> no register change, sel=0, MemR there -> RD=0 with RD_valid.
REQ-036 IE=0x01, gpio_in[0] 0->1 -> IS=0x01 after 3 cycles, irq=1 after 4; write IS=0x01 -> irq=0 two cycles later.
REQ-037 Write-1-to-clear IS[0] in the same cycle as a new rise on pin 0 -> IS[0] remains 1, irq stays 1.
REQ-038 DIR=0xF0, OUT=0x3C, then rst_n pulsed low between edges -> gpio_out=0, gpio_oe=0, irq=0 immediately.
REQ-039 WIDTH=32, SYNC_STAGES=3: write OUT=0xDEADBEEF, read back 0xDEADBEEF; pin rise -> IS set after 4 cycles.
